// File: rtl/line_bridge_pkg.sv
// Shared types and helpers for the cache-line to narrow-memory bridge.
package line_bridge_pkg;

    localparam int LB_LINE_WIDTH = 128;
    localparam int LB_MEM_WIDTH  = 32;
    localparam int LB_BEATS      = LB_LINE_WIDTH / LB_MEM_WIDTH;
    localparam int LB_IDX_W      = $clog2(LB_BEATS);
    localparam int LB_BEAT_SH    = $clog2(LB_MEM_WIDTH / 8);

    typedef enum logic [1:0] {
        LB_IDLE   = 2'd0,
        LB_REQ    = 2'd1,
        LB_WAIT_R = 2'd2,
        LB_RESP   = 2'd3
    } lb_state_e;

    // Byte address of beat idx within the line containing addr.
    function automatic logic [31:0] beat_addr(input logic [31:0] addr,
                                              input logic [LB_IDX_W-1:0] idx);
        beat_addr = (addr & ~32'(LB_LINE_WIDTH / 8 - 1)) | (32'(idx) << LB_BEAT_SH);
    endfunction

endpackage

// File: rtl/data_line_mem_bridge.sv
// Splits one cache-line read/write into single-outstanding 32-bit memory beats.
// Optional LINE_BRIDGE_SKIP_EMPTY_EN: write beats with all-zero byte enables are skipped.
module data_line_mem_bridge
    import line_bridge_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int MEM_WIDTH  = 32,
    parameter int BEATS      = LINE_WIDTH / MEM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ln_en_i,
    input  logic [31:0]             ln_addr_i,
    input  logic [LINE_WIDTH-1:0]   ln_wdata_i,
    input  logic                    ln_we_i,
    input  logic [LINE_WIDTH/8-1:0] ln_be_i,
    output logic                    ln_gnt_o,
    output logic                    ln_rvalid_o,
    output logic [LINE_WIDTH-1:0]   ln_rdata_o,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    output logic [MEM_WIDTH-1:0]    mem_wdata_o,
    output logic                    mem_we_o,
    output logic [MEM_WIDTH/8-1:0]  mem_be_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [MEM_WIDTH-1:0]    mem_rdata_i
);

    localparam int MB    = MEM_WIDTH / 8;
    localparam int LB    = LINE_WIDTH / 8;
    localparam int IDX_W = LB_IDX_W;
    localparam int CNT_W = IDX_W + 1;

    lb_state_e             state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [31:0]           addr_reg;
    logic [LINE_WIDTH-1:0] wdata_reg;
    logic [LB-1:0]         be_reg;
    logic [LINE_WIDTH-1:0] line_reg;

    logic                  issue;
    logic [31:0]           src_addr;
    logic [LINE_WIDTH-1:0] src_wdata;
    logic [LB-1:0]         src_be;
    logic [CNT_W-1:0]      start_cnt;
    logic [CNT_W-1:0]      nxt_cnt;
    logic                  nxt_done;
    logic [IDX_W-1:0]      nxt_idx;
    logic [MEM_WIDTH-1:0]  beat_wdata;
    logic [MB-1:0]         beat_be;

`ifdef LINE_BRIDGE_SKIP_EMPTY_EN
    // First beat at or after start that carries data; BEATS when none is left.
    function automatic logic [CNT_W-1:0] next_beat(input logic [LB-1:0] be,
                                                   input logic we,
                                                   input logic [CNT_W-1:0] start);
        next_beat = CNT_W'(BEATS);
        for (int j = BEATS - 1; j >= 0; j--) begin
            if (CNT_W'(j) >= start && (!we || (|be[j*MB +: MB])))
                next_beat = CNT_W'(j);
        end
    endfunction
`endif

    assign ln_gnt_o    = rst_n && ln_en_i && (state_reg == LB_IDLE || state_reg == LB_RESP);
    assign ln_rvalid_o = (state_reg == LB_RESP);
    assign ln_rdata_o  = line_reg;

    // A beat is launched either from a fresh grant or from the previous beat's response.
    assign issue = ln_gnt_o || (state_reg == LB_WAIT_R && mem_rvalid_i);

    always_comb begin
        src_addr  = ln_gnt_o ? ln_addr_i  : addr_reg;
        src_wdata = ln_gnt_o ? ln_wdata_i : wdata_reg;
        src_be    = ln_gnt_o ? ln_be_i    : be_reg;
        start_cnt = ln_gnt_o ? '0 : CNT_W'(idx_reg) + CNT_W'(1);
`ifdef LINE_BRIDGE_SKIP_EMPTY_EN
        nxt_cnt   = next_beat(src_be, ln_gnt_o ? ln_we_i : mem_we_o, start_cnt);
`else
        nxt_cnt   = start_cnt;
`endif
        nxt_done   = nxt_cnt[IDX_W];
        nxt_idx    = nxt_cnt[IDX_W-1:0];
        beat_wdata = src_wdata[nxt_idx*MEM_WIDTH +: MEM_WIDTH];
        beat_be    = src_be[nxt_idx*MB +: MB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= LB_IDLE;
            idx_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            line_reg    <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            mem_we_o    <= 1'b0;
        end else begin
            if (ln_gnt_o) begin
                addr_reg  <= ln_addr_i;
                wdata_reg <= ln_wdata_i;
                be_reg    <= ln_be_i;
                mem_we_o  <= ln_we_i;
            end
            if (state_reg == LB_WAIT_R && mem_rvalid_i && !mem_we_o)
                line_reg[idx_reg*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata_i;

            if (issue) begin
                if (nxt_done) begin
                    state_reg <= LB_RESP;
                end else begin
                    state_reg   <= LB_REQ;
                    idx_reg     <= nxt_idx;
                    mem_req_o   <= 1'b1;
                    mem_addr_o  <= beat_addr(src_addr, nxt_idx);
                    mem_wdata_o <= beat_wdata;
                    mem_be_o    <= beat_be;
                end
            end else if (state_reg == LB_REQ && mem_gnt_i) begin
                mem_req_o <= 1'b0;
                state_reg <= LB_WAIT_R;
            end else if (state_reg == LB_RESP) begin
                state_reg <= LB_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_data_line_mem_bridge.sv
// Directed bench for data_line_mem_bridge with a small single-beat memory responder.
module tb_data_line_mem_bridge;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ln_en_i = 1'b0;
    logic [31:0]  ln_addr_i = '0;
    logic [127:0] ln_wdata_i = '0;
    logic         ln_we_i = 1'b0;
    logic [15:0]  ln_be_i = '0;
    logic         ln_gnt_o;
    logic         ln_rvalid_o;
    logic [127:0] ln_rdata_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_we_o;
    logic [3:0]   mem_be_o;
    logic         mem_gnt_i = 1'b0;
    logic         mem_rvalid_i = 1'b0;
    logic [31:0]  mem_rdata_i = '0;

    always #5 clk = ~clk;

    data_line_mem_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .ln_en_i(ln_en_i), .ln_addr_i(ln_addr_i), .ln_wdata_i(ln_wdata_i),
        .ln_we_i(ln_we_i), .ln_be_i(ln_be_i), .ln_gnt_o(ln_gnt_o),
        .ln_rvalid_o(ln_rvalid_o), .ln_rdata_o(ln_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Responder knobs and beat log.
    int          cyc = 0;
    int          stall_cfg = 0;
    int          rv_wait = 0;
    logic [31:0] rd_xor = '0;
    logic        spur_rv = 1'b0;
    int          stall_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] log_addr [64];
    logic [31:0] log_wdata [64];
    logic [3:0]  log_be [64];
    logic        log_we [64];
    int          log_n = 0;
    int          rv_cnt = 0;
    int          rv_cyc = 0;
    int          gnt_cyc = 0;
    int          unstable = 0;
    logic        req_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    logic [31:0] wdata_prev = '0;
    logic [3:0]  be_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            stall_cnt    = 0;
            resp_cnt     = 0;
            req_prev     = 1'b0;
        end else begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = spur_rv;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pend_data;
                end
            end else if (mem_req_o) begin
                if (stall_cnt < stall_cfg) begin
                    stall_cnt++;
                end else begin
                    mem_gnt_i = 1'b1;
                    stall_cnt = 0;
                    resp_cnt  = rv_wait + 1;
                    pend_data = (32'h11111111 * (32'(mem_addr_o[3:2]) + 32'd1)) ^ rd_xor;
                    if (log_n < 64) begin
                        log_addr[log_n]  = mem_addr_o;
                        log_wdata[log_n] = mem_wdata_o;
                        log_be[log_n]    = mem_be_o;
                        log_we[log_n]    = mem_we_o;
                        log_n++;
                    end
                end
            end
            if (mem_req_o && req_prev &&
                (mem_addr_o !== addr_prev || mem_wdata_o !== wdata_prev || mem_be_o !== be_prev))
                unstable++;
            req_prev   = mem_req_o;
            addr_prev  = mem_addr_o;
            wdata_prev = mem_wdata_o;
            be_prev    = mem_be_o;
            if (ln_gnt_o) gnt_cyc = cyc;
            if (ln_rvalid_o) begin
                rv_cnt++;
                rv_cyc = cyc;
            end
        end
    end

    task automatic start_line(input logic we, input logic [31:0] addr, input logic [127:0] wdata,
                              input logic [15:0] be);
        @(posedge clk); #1;
        ln_en_i = 1'b1; ln_we_i = we; ln_addr_i = addr; ln_wdata_i = wdata; ln_be_i = be;
        #1 check_val("gnt", ln_gnt_o, 1'b1);
        @(posedge clk); #1;
        ln_en_i = 1'b0;
    endtask

    task automatic wait_done(input int rv0, output int lat);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ln_rvalid_o) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("done", done, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_val("one_rvalid", 32'(rv_cnt - rv0), 1);
        lat = rv_cyc - gnt_cyc;
    endtask

    task automatic run_line(input logic we, input logic [31:0] addr, input logic [127:0] wdata,
                            input logic [15:0] be, output int lat, output int first);
        int rv0;
        first = log_n;
        rv0 = rv_cnt;
        start_line(we, addr, wdata, be);
        wait_done(rv0, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, first, rv0, n0;
        bit hit;
        logic [127:0] line0, exp_line;
        line0 = 128'h44444444_33333333_22222222_11111111;

        // Reset values, with a request pending to show grant is held off.
        ln_en_i = 1'b1;
        #12;
        check_val("rst_gnt", ln_gnt_o, 1'b0);
        check_val("rst_req", mem_req_o, 1'b0);
        check_val("rst_rvalid", ln_rvalid_o, 1'b0);
        check_val("rst_addr", mem_addr_o, 32'h0);
        check_val("rst_rdata", ln_rdata_o, 128'h0);
        ln_en_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Zero-wait refill.
        run_line(1'b0, 32'h0000_010C, '0, 16'hFFFF, lat, first);
        check_val("rd_beats", 32'(log_n - first), 4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("rd_addr%0d", k), log_addr[first+k], 32'h100 + 32'(4*k));
            check_val($sformatf("rd_we%0d", k), log_we[first+k], 1'b0);
        end
        check_val("rd_line", ln_rdata_o, line0);
        check_val("rd_latency", 32'(lat), 9);

        // Full write with two-cycle grant stalls.
        stall_cfg = 2;
        unstable = 0;
        run_line(1'b1, 32'h0000_02A0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'hFFFF, lat, first);
        stall_cfg = 0;
        check_val("wr_beats", 32'(log_n - first), 4);
        check_val("wr_addr0", log_addr[first], 32'h2A0);
        check_val("wr_addr3", log_addr[first+3], 32'h2AC);
        check_val("wr_data0", log_wdata[first], 32'hAAAAAAAA);
        check_val("wr_data2", log_wdata[first+2], 32'hCCCCCCCC);
        check_val("wr_be1", log_be[first+1], 4'hF);
        check_val("wr_we3", log_we[first+3], 1'b1);
        check_val("wr_stable", 32'(unstable), 0);
        check_val("wr_latency", 32'(lat), 17);
        check_val("wr_keeps_rdata", ln_rdata_o, line0);

        // Sparse write: only beat 1 carries enables.
        run_line(1'b1, 32'h0000_0340, 128'h44444444_33333333_22222222_11111111, 16'h00F0, lat, first);
`ifdef LINE_BRIDGE_SKIP_EMPTY_EN
        check_val("sp_beats", 32'(log_n - first), 1);
        check_val("sp_addr", log_addr[first], 32'h344);
        check_val("sp_be", log_be[first], 4'hF);
        check_val("sp_data", log_wdata[first], 32'h22222222);
`else
        check_val("sp_beats", 32'(log_n - first), 4);
        check_val("sp_be0", log_be[first], 4'h0);
        check_val("sp_be1", log_be[first+1], 4'hF);
        check_val("sp_be2", log_be[first+2], 4'h0);
        check_val("sp_be3", log_be[first+3], 4'h0);
`endif

        // Write with no enables at all.
        run_line(1'b1, 32'h0000_0380, '1, 16'h0000, lat, first);
`ifdef LINE_BRIDGE_SKIP_EMPTY_EN
        check_val("empty_beats", 32'(log_n - first), 0);
        check_val("empty_latency", 32'(lat), 1);
`else
        check_val("empty_beats", 32'(log_n - first), 4);
        check_val("empty_latency", 32'(lat), 9);
`endif

        // Spurious memory response while idle.
        rv0 = rv_cnt;
        @(posedge clk); #1;
        spur_rv = 1'b1;
        @(posedge clk); #1;
        spur_rv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("spur_req", mem_req_o, 1'b0);
        check_val("spur_rvalid", 32'(rv_cnt - rv0), 0);
        check_val("spur_rdata", ln_rdata_o, line0);

        // Line request while a beat response is outstanding.
        rv_wait = 3;
        rv0 = rv_cnt;
        first = log_n;
        start_line(1'b0, 32'h0000_0500, '0, 16'hFFFF);
        @(posedge clk); #1;
        ln_en_i = 1'b1; ln_addr_i = 32'h900;
        #1 check_val("waitr_gnt_a", ln_gnt_o, 1'b0);
        @(posedge clk); #1;
        check_val("waitr_gnt_b", ln_gnt_o, 1'b0);
        check_val("waitr_req", mem_req_o, 1'b0);
        ln_en_i = 1'b0;
        wait_done(rv0, lat);
        rv_wait = 0;
        check_val("waitr_beats", 32'(log_n - first), 4);
        check_val("waitr_addr0", log_addr[first], 32'h500);

        // Back-to-back: new request presented in the completion cycle.
        rv0 = rv_cnt;
        start_line(1'b0, 32'h0000_0300, '0, 16'hFFFF);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ln_rvalid_o) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("b2b_first_done", hit, 1'b1);
        ln_en_i = 1'b1; ln_we_i = 1'b1; ln_addr_i = 32'h400;
        ln_wdata_i = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A; ln_be_i = 16'hFFFF;
        #1 check_val("b2b_gnt", ln_gnt_o, 1'b1);
        @(posedge clk); #1;
        ln_en_i = 1'b0;
        check_val("b2b_req", mem_req_o, 1'b1);
        check_val("b2b_addr", mem_addr_o, 32'h400);
        check_val("b2b_wdata", mem_wdata_o, 32'h0A0A0A0A);
        wait_done(rv0 + 1, lat);

        // Reset pulse after beat 2's grant.
        rv_wait = 2;
        rv0 = rv_cnt;
        first = log_n;
        start_line(1'b0, 32'h0000_0600, '0, 16'hFFFF);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (log_n >= first + 3) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("mr_reach_beat2", hit, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("mr_req", mem_req_o, 1'b0);
        check_val("mr_addr", mem_addr_o, 32'h0);
        check_val("mr_be", mem_be_o, 4'h0);
        check_val("mr_rdata", ln_rdata_o, 128'h0);
        check_val("mr_rvalid", ln_rvalid_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv_wait = 0;
        n0 = log_n;
        repeat (6) @(posedge clk);
        #1;
        check_val("mr_no_rvalid", 32'(rv_cnt - rv0), 0);
        check_val("mr_no_beats", 32'(log_n - n0), 0);

        // Fresh refill after the reset.
        rd_xor = 32'hA5A5A5A5;
        run_line(1'b0, 32'h0000_0700, '0, 16'hFFFF, lat, first);
        exp_line = 128'hE1E1E1E1_96969696_87878787_B4B4B4B4;
        check_val("post_rst_line", ln_rdata_o, exp_line);
        check_val("post_rst_latency", 32'(lat), 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_line_mem_bridge.md
# data_line_mem_bridge

Downstream companion of the L0 data cache: converts the cache's single 128-bit line transaction (refill read or dirty-line write-back) into a sequence of 32-bit beats on the narrow data-memory port. Read beats are assembled into one line that is returned with a single `ln_rvalid_o` pulse. A write completes with the same `ln_rvalid_o` pulse, which is what the cache waits on before issuing its refill.

## Interface
- `LINE_WIDTH`, default 128: cache-side line width, in bits.
- `MEM_WIDTH`, default 32: memory-side beat width, in bits.
- `BEATS`, default `LINE_WIDTH/MEM_WIDTH` (4): beats per line; must be a power of two.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ln_en_i`, input, 1: line request.
- `ln_addr_i`, input, 32: line address; bits [3:0] are ignored.
- `ln_wdata_i`, input, LINE_WIDTH: write line.
- `ln_we_i`, input, 1: 1 means write-back, 0 means refill.
- `ln_be_i`, input, LINE_WIDTH/8: byte enables.
- `ln_gnt_o`, output, 1: request accepted in this cycle.
- `ln_rvalid_o`, output, 1: one-cycle completion pulse, for both reads and writes.
- `ln_rdata_o`, output, LINE_WIDTH: assembled read line.
- `mem_req_o`, output, 1: beat request.
- `mem_addr_o`, output, 32: beat byte address.
- `mem_wdata_o`, output, MEM_WIDTH: beat write data.
- `mem_we_o`, output, 1: beat write enable.
- `mem_be_o`, output, MEM_WIDTH/8: beat byte enables.
- `mem_gnt_i`, input, 1: beat accepted.
- `mem_rvalid_i`, input, 1: beat response; arrives at least 1 cycle after `mem_gnt_i`.
- `mem_rdata_i`, input, MEM_WIDTH: beat read data.

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - REQ: `mem_req_o` asserted, waiting for `mem_gnt_i`.
  - WAIT_R: waiting for `mem_rvalid_i`.
  - RESP: `ln_rvalid_o` high.
- Accepting a request:
  - `ln_gnt_o = ln_en_i && (state==IDLE || state==RESP)`, combinational, so the cache can issue back-to-back requests on its completion cycle.
  - On grant, capture addr/wdata/we/be, clear the beat index, then go to REQ.
- Beat k addressing and data:
  - `mem_addr_o = {addr[31:4], k[1:0], 2'b00}`.
  - `mem_wdata_o`/`mem_be_o` = slice k of the captured wdata/be.
  - `mem_we_o` = captured `we`.
- Beat sequencing:
  - REQ to WAIT_R on `mem_gnt_i`.
  - WAIT_R on `mem_rvalid_i`:
    - a read stores `mem_rdata_i` into slice k of the line register;
    - if k==BEATS-1, go to RESP;
    - otherwise k++ and go to REQ.
- RESP: `ln_rvalid_o`=1 and `ln_rdata_o` holds the assembled line. Next state is REQ if a new grant occurs in the same cycle, else IDLE.
- `ln_rdata_o` holds its value until the next read completes. After a write it holds the previous read value.
- Only one beat is outstanding at a time. `mem_rvalid_i` outside WAIT_R is ignored.
- `ln_en_i` outside IDLE/RESP is not granted. The cache re-presents the request, and it is accepted later.

## Timing
- Reset values:
  - `mem_req_o`, `mem_we_o`, `ln_rvalid_o` and `ln_gnt_o` are 0 (`ln_gnt_o` is combinational and forced 0 in reset).
  - `mem_addr_o`, `mem_wdata_o`, `mem_be_o` and `ln_rdata_o` are 0.
  - State is IDLE.
- Latency with a zero-wait memory (gnt in the same cycle, rvalid the next cycle):
  - grant at cycle 0;
  - beat k requested at cycle 1+2k;
  - last rvalid at cycle 8;
  - `ln_rvalid_o` at cycle 9.
- `mem_req_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o` and `mem_we_o` are registered and stay stable while waiting for grant.
- If `mem_gnt_i` and `mem_rvalid_i` arrive in the same cycle in REQ, the rvalid is ignored: it belongs to no outstanding beat.
- Reset mid-transaction: the FSM returns to IDLE, no `ln_rvalid_o` is produced, and a partial line is discarded.

## Configuration
- `LINE_BRIDGE_SKIP_EMPTY_EN`:
  - Defined:
    - write beats whose byte-enable slice is all zero are skipped (no `mem_req_o`), and the next non-empty beat is selected combinationally from the beat index;
    - a write with `ln_be_i`==0 goes straight to RESP, with `ln_rvalid_o` at cycle 1.
  - Undefined: every write issues all BEATS beats, including zero-enable beats.
  - Reads always issue all beats.

## Structure
- Package `line_bridge_pkg` holds:
  - the state enum typedef `lb_state_e`;
  - localparams `LB_BEATS` and `LB_IDX_W = $clog2(LB_BEATS)`;
  - the function `beat_addr(addr, idx)`.
- No sub-module. Slice select and line assembly are indexed part-selects in the single module.

## Test plan
- Read at addr 0x100, memory returning beat 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 with zero wait:
  - `mem_addr_o` sequence is 0x100, 0x104, 0x108, 0x10C;
  - `ln_rdata_o` = 0x44444444_33333333_22222222_11111111;
  - `ln_rvalid_o` is high at cycle 9.
- Write at 0x2A0 with be=0xFFFF and 2-cycle `mem_gnt_i` stalls: each beat's addr/data is held stable during the stall, 4 writes are issued, and there is one `ln_rvalid_o` pulse.
- Write with be=0x00F0, macro defined: only beat 1 is issued (addr +4, be=0xF). With the macro undefined: 4 beats, with be 0x0, 0xF, 0x0, 0x0.
- Back-to-back requests: a second `ln_en_i` in the RESP cycle gets `ln_gnt_o`=1 and its first `mem_req_o` appears in the next cycle.
- Spurious `mem_rvalid_i` in IDLE, and `ln_en_i` during WAIT_R: no state change, no grant, no `ln_rvalid_o`.
- `rst_n` pulsed low after beat 2's grant: all outputs go to 0 asynchronously, there is no `ln_rvalid_o`, and a following read completes normally.
